// File: rtl/sha256_core_arbiter_if.sv
// sha256_core_arbiter_if: requester, engine and result signals of sha256_core_arbiter
// Requester side: req_i, req_word_i (slice i = [32*i+31:32*i]), req_valid_i, req_last_i, req_ready_o, grant_o
// Engine side:    core_start_o, core_first_o, core_word_o, core_word_valid_o, core_done_i
// Result side:    res_valid_o, res_id_o, res_blocks_o, res_ready_i, err_o
// master = environment (requesters, engine, result consumer); slave = the arbiter
interface sha256_core_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ),
    parameter int BLKW = 8
);
    logic [NREQ-1:0]    req_i;
    logic [NREQ*32-1:0] req_word_i;
    logic [NREQ-1:0]    req_valid_i;
    logic [NREQ-1:0]    req_last_i;
    logic [NREQ-1:0]    req_ready_o;
    logic [NREQ-1:0]    grant_o;
    logic               core_start_o;
    logic               core_first_o;
    logic [31:0]        core_word_o;
    logic               core_word_valid_o;
    logic               core_done_i;
    logic               res_valid_o;
    logic [IDW-1:0]     res_id_o;
    logic [BLKW-1:0]    res_blocks_o;
    logic               res_ready_i;
    logic               err_o;
    modport master (
        output req_i, req_word_i, req_valid_i, req_last_i, core_done_i, res_ready_i,
        input  req_ready_o, grant_o, core_start_o, core_first_o, core_word_o, core_word_valid_o,
               res_valid_o, res_id_o, res_blocks_o, err_o
    );
    modport slave (
        input  req_i, req_word_i, req_valid_i, req_last_i, core_done_i, res_ready_i,
        output req_ready_o, grant_o, core_start_o, core_first_o, core_word_o, core_word_valid_o,
               res_valid_o, res_id_o, res_blocks_o, err_o
    );
endinterface

// File: rtl/sha256_core_arbiter.sv
// sha256_core_arbiter: round-robin sharing of one SHA-256 engine, granted per whole multi-block message
// Ports: clk; rst_n (asynchronous, active-low); bus (sha256_core_arbiter_if.slave) carrying
//   requester words/handshake and one-hot grant, engine start/first/word/done, result slot and err_o.
// Optional: define SHA_ARB_WDOG_EN for a TMO_CYC-cycle watchdog in WAIT (sticky err_o); otherwise err_o = 0.
module sha256_core_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = $clog2(NREQ),
    parameter int BLKW    = 8,
    parameter int TMO_CYC = 128
) (
    input logic                  clk,
    input logic                  rst_n,
    sha256_core_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, START, LOAD, WAIT, RESULT} state_t;
    state_t          state, state_d;
    logic [IDW-1:0]  ptr, owner, sel, idx, owner_nxt;
    logic            found, accept, timeout, last_q;
    logic [NREQ-1:0] grant;
    logic [3:0]      word_cnt;
    logic [BLKW-1:0] blk_cnt;
`ifdef SHA_ARB_WDOG_EN
    localparam int WDW = $clog2(TMO_CYC + 1);
    logic [WDW-1:0] wd_cnt;
    logic           err;
    assign timeout   = state == WAIT && !bus.core_done_i && wd_cnt == WDW'(TMO_CYC - 1);
    assign bus.err_o = err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            wd_cnt <= state == WAIT ? wd_cnt + 1'b1 : '0;
            if (timeout) err <= 1'b1;
        end
    end
`else
    assign timeout   = 1'b0;
    assign bus.err_o = 1'b0;
`endif
    // Scan downward in offset so the lowest offset from ptr is the last (winning) assignment.
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (bus.req_i[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end
    assign owner_nxt = owner == IDW'(NREQ - 1) ? '0 : owner + 1'b1;
    assign accept    = state == LOAD && bus.req_valid_i[owner];
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = found ? START : IDLE;
            START:   state_d = LOAD;
            LOAD:    state_d = accept && &word_cnt ? WAIT : LOAD;
            WAIT:    state_d = bus.core_done_i ? (last_q ? RESULT : START) : timeout ? IDLE : WAIT;
            RESULT:  state_d = bus.res_ready_i ? IDLE : RESULT;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            grant    <= '0;
            word_cnt <= '0;
            blk_cnt  <= '0;
            last_q   <= 1'b0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: if (found) begin
                    owner   <= sel;
                    grant   <= NREQ'(1) << sel;
                    blk_cnt <= '0;
                end
                START: word_cnt <= '0;
                LOAD: if (accept) begin
                    word_cnt <= word_cnt + 1'b1;
                    if (&word_cnt) begin
                        last_q  <= bus.req_last_i[owner];
                        blk_cnt <= &blk_cnt ? blk_cnt : blk_cnt + 1'b1;
                    end
                end
                WAIT: if (timeout) begin
                    ptr     <= owner_nxt;
                    grant   <= '0;
                    blk_cnt <= '0;
                    last_q  <= 1'b0;
                end
                RESULT: if (bus.res_ready_i) begin
                    ptr     <= owner_nxt;
                    grant   <= '0;
                    blk_cnt <= '0;
                    last_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end
    assign bus.grant_o           = grant;
    assign bus.req_ready_o       = state == LOAD ? grant : '0;
    assign bus.core_start_o      = state == START;
    assign bus.core_first_o      = state == START && blk_cnt == '0;
    assign bus.core_word_o       = state == LOAD ? bus.req_word_i[{owner, 5'd0} +: 32] : '0;
    assign bus.core_word_valid_o = accept;
    assign bus.res_valid_o       = state == RESULT;
    assign bus.res_id_o          = state == RESULT ? owner : '0;
    assign bus.res_blocks_o      = state == RESULT ? blk_cnt : '0;
endmodule

// File: tb/tb_sha256_core_arbiter.sv
// tb_sha256_core_arbiter: scoreboard bench for sha256_core_arbiter (directed messages, queued expectations)
module tb_sha256_core_arbiter;
    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int BLKW    = 8;
    localparam int TMO_CYC = 128;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [35:0] exp_word[$];
    logic [4:0]  exp_start[$];
    logic [9:0]  exp_res[$];
    sha256_core_arbiter_if #(.NREQ(NREQ), .IDW(IDW), .BLKW(BLKW)) bus ();
    sha256_core_arbiter #(.NREQ(NREQ), .IDW(IDW), .BLKW(BLKW), .TMO_CYC(TMO_CYC)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask
    task automatic miss(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s got %h expected nothing", name, act);
    endtask
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    function automatic logic [63:0] outs();
        return 64'({bus.err_o, bus.grant_o, bus.req_ready_o, bus.core_start_o, bus.core_first_o,
                    bus.core_word_valid_o, bus.res_valid_o, bus.res_id_o, bus.res_blocks_o, bus.core_word_o});
    endfunction
    task automatic monitor();
        logic [35:0] w;
        logic [4:0]  s;
        logic [9:0]  r;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.core_start_o) begin
                    if (exp_start.size() != 0) begin
                        s = exp_start.pop_front();
                        chk("core_start grant/first", {bus.grant_o, bus.core_first_o}, s);
                    end else miss("core_start", {bus.grant_o, bus.core_first_o});
                end
                if (bus.core_word_valid_o) begin
                    if (exp_word.size() != 0) begin
                        w = exp_word.pop_front();
                        chk("core_word grant/word", {bus.grant_o, bus.core_word_o}, w);
                    end else miss("core_word", {bus.grant_o, bus.core_word_o});
                end
                if (bus.res_valid_o && bus.res_ready_i) begin
                    if (exp_res.size() != 0) begin
                        r = exp_res.pop_front();
                        chk("result id/blocks", {bus.res_id_o, bus.res_blocks_o}, r);
                    end else miss("result", {bus.res_id_o, bus.res_blocks_o});
                end
            end
        end
    endtask
    // Drives one message of requester id; word = block<<8 | index. gap idle cycles precede each word;
    // dly < 0 withholds core_done_i; abort_at >= 0 stops after that many accepted words.
    task automatic serve(input int id, input int nblk, input int gap, input int dly, input int abort_at);
        int n;
        int cnt;
        logic [31:0] word;
        exp_start.push_back({4'(1 << id), 1'b1});
        n = 0;
        while (bus.grant_o != 4'(1 << id) && n < 500) begin
            tick();
            n++;
        end
        if (n == 500) begin
            miss("grant_timeout", 64'(bus.grant_o));
            return;
        end
        cnt = 0;
        for (int b = 0; b < nblk; b++) begin
            for (int w = 0; w < 16; w++) begin
                bus.req_valid_i[id] = 1'b0;
                if (abort_at == cnt) return;
                tick(gap);
                word = 32'((b << 8) | w);
                bus.req_word_i[32*id +: 32] = word;
                bus.req_last_i[id] = (b == nblk - 1) && (w == 15);
                exp_word.push_back({4'(1 << id), word});
                bus.req_valid_i[id] = 1'b1;
                n = 0;
                while (!bus.req_ready_o[id] && n < 100) begin
                    tick();
                    n++;
                end
                if (n == 100) begin
                    miss("ready_timeout", 64'(bus.req_ready_o));
                    bus.req_valid_i[id] = 1'b0;
                    return;
                end
                tick();
                cnt++;
            end
            bus.req_valid_i[id] = 1'b0;
            bus.req_last_i[id] = 1'b0;
            if (dly < 0) return;
            tick(dly);
            if (b == nblk - 1) exp_res.push_back({2'(id), 8'(nblk)});
            else exp_start.push_back({4'(1 << id), 1'b0});
            bus.core_done_i = 1'b1;
            tick();
            bus.core_done_i = 1'b0;
        end
    endtask
    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end
    initial begin
        bus.req_i = '0;
        bus.req_word_i = '0;
        bus.req_valid_i = '0;
        bus.req_last_i = '0;
        bus.core_done_i = 1'b0;
        bus.res_ready_i = 1'b1;
        fork
            monitor();
        join_none
        tick(3);
        chk("reset_outputs", outs(), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_outputs", outs(), 64'd0);
        // all four requesting from pointer 0: order 0,1,2,3,0
        bus.req_i = 4'b1111;
        serve(0, 1, 0, 3, -1);
        serve(1, 1, 0, 3, -1);
        bus.req_i[1] = 1'b0;
        serve(2, 1, 0, 3, -1);
        bus.req_i[2] = 1'b0;
        serve(3, 1, 0, 3, -1);
        bus.req_i[3] = 1'b0;
        serve(0, 1, 0, 3, -1);
        bus.req_i = '0;
        tick(3);
        // three-block message from requester 0
        bus.req_i = 4'b0001;
        serve(0, 3, 0, 3, -1);
        bus.req_i = '0;
        tick(3);
        // single block from requester 2, done 64 cycles after the last word
        bus.req_i = 4'b0100;
        serve(2, 1, 0, 64, -1);
        bus.req_i = '0;
        tick(3);
        // requester 1 with a word every third cycle
        bus.req_i = 4'b0010;
        serve(1, 1, 2, 3, -1);
        bus.req_i = '0;
        tick(3);
        // pointer is now 2: requester 3 wins, then reset mid-load restores pointer 0
        bus.req_i = 4'b1010;
        serve(3, 1, 0, 3, 8);
        chk("load_before_reset", 64'(bus.req_ready_o), 64'(4'b1000));
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", outs(), 64'd0);
        tick();
        chk("reset_next_edge_outputs", outs(), 64'd0);
        exp_word.delete();
        exp_start.delete();
        exp_res.delete();
        rst_n = 1'b1;
        serve(1, 1, 0, 3, -1);
        bus.req_i = '0;
        tick(3);
`ifdef SHA_ARB_WDOG_EN
        // pointer is 2: requester 2 wins, done withheld, watchdog hands over to requester 0
        bus.req_i = 4'b0101;
        serve(2, 1, 0, -1, -1);
        tick(TMO_CYC - 1);
        chk("err_before_timeout", 64'(bus.err_o), 64'd0);
        chk("grant_before_timeout", 64'(bus.grant_o), 64'(4'b0100));
        tick();
        chk("err_at_timeout", 64'(bus.err_o), 64'd1);
        chk("grant_cleared_at_timeout", 64'(bus.grant_o), 64'd0);
        chk("no_result_at_timeout", 64'(bus.res_valid_o), 64'd0);
        bus.req_i[2] = 1'b0;
        serve(0, 1, 0, 3, -1);
        bus.req_i = '0;
        tick(3);
        chk("err_sticky", 64'(bus.err_o), 64'd1);
`else
        chk("err_off", 64'(bus.err_o), 64'd0);
`endif
        tick(3);
        chk("scoreboard_drained", 64'(exp_word.size() + exp_start.size() + exp_res.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
